// File: rtl/matmul_seq_ctrl_if.sv
// matmul_seq_ctrl_if
// Host / Q_RAM / dot-product bundle for the matrix-product sequencer.
//   master : host/loader side (drives start, abort, host_*, res_ready)
//   slave  : sequencer side   (drives we, dir_*, dot_go, res_*, busy, done)
// Signals:
//   start, abort            command inputs
//   host_we, host_dir_m1/2  loader write enables / addresses
//   we, dir_m1, dir_m2      Q_RAM write enables / addresses
//   dot_go                  dot-product start strobe
//   res_valid, res_ready    result handshake, res_idx = i*DIM+j
//   busy, done              status
// Optional macro SEQ_PERF_CNT_EN adds perf_cycles / perf_stalls.
interface matmul_seq_ctrl_if #(
    parameter int unsigned DIM    = 8,
    parameter int unsigned ADDR_W = 7
);
    localparam int unsigned IDX_W = 2 * $clog2(DIM);

    logic              start;
    logic              abort;
    logic [3:0]        host_we;
    logic [ADDR_W-1:0] host_dir_m1;
    logic [ADDR_W-1:0] host_dir_m2;
    logic [3:0]        we;
    logic [ADDR_W-1:0] dir_m1;
    logic [ADDR_W-1:0] dir_m2;
    logic              dot_go;
    logic              res_valid;
    logic              res_ready;
    logic [IDX_W-1:0]  res_idx;
    logic              busy;
    logic              done;

`ifdef SEQ_PERF_CNT_EN
    logic [15:0]       perf_cycles;
    logic [15:0]       perf_stalls;

    modport master (
        output start, abort, host_we, host_dir_m1, host_dir_m2, res_ready,
        input  we, dir_m1, dir_m2, dot_go, res_valid, res_idx, busy, done,
               perf_cycles, perf_stalls
    );
    modport slave (
        input  start, abort, host_we, host_dir_m1, host_dir_m2, res_ready,
        output we, dir_m1, dir_m2, dot_go, res_valid, res_idx, busy, done,
               perf_cycles, perf_stalls
    );
`else
    modport master (
        output start, abort, host_we, host_dir_m1, host_dir_m2, res_ready,
        input  we, dir_m1, dir_m2, dot_go, res_valid, res_idx, busy, done
    );
    modport slave (
        input  start, abort, host_we, host_dir_m1, host_dir_m2, res_ready,
        output we, dir_m1, dir_m2, dot_go, res_valid, res_idx, busy, done
    );
`endif
endinterface

// File: rtl/matmul_seq_ctrl.sv
// matmul_seq_ctrl
// Sequencer and Q_RAM port owner for a DIM x DIM complex matrix product.
// In IDLE the host loader's write enables / addresses pass straight to
// Q_RAM; once started, the block walks every output element (i,j),
// addresses row i of M1 and row j of M2 (M2 is stored transposed), strobes
// the dot-product unit and offers each result under valid/ready.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : matmul_seq_ctrl_if.slave (see interface header)
// Optional macro SEQ_PERF_CNT_EN: busy-cycle and stall counters
// (bus.perf_cycles, bus.perf_stalls), saturating, cleared on start.
module matmul_seq_ctrl #(
    parameter int unsigned DIM      = 8,
    parameter int unsigned ADDR_W   = 7,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned PIPE_LAT = 3
) (
    input  logic                clk,
    input  logic                rst,
    matmul_seq_ctrl_if.slave    bus
);
    localparam int unsigned IJ_W     = $clog2(DIM);
    localparam int unsigned IDX_W    = 2 * IJ_W;
    localparam int unsigned WAIT_MAX = (RD_LAT > PIPE_LAT) ? RD_LAT : PIPE_LAT;
    localparam int unsigned CNT_W    = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

    localparam logic [IJ_W-1:0]  LAST   = IJ_W'(DIM - 1);
    localparam logic [CNT_W-1:0] RD_END = CNT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0] EX_END = CNT_W'(PIPE_LAT - 1);

    typedef enum logic [2:0] {
        IDLE, ISSUE, RD_WAIT, FIRE, EXEC, OUT, DONE
    } state_t;

    state_t           state, state_nxt;
    logic [IJ_W-1:0]  i_q, i_nxt;
    logic [IJ_W-1:0]  j_q, j_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            i_q   <= '0;
            j_q   <= '0;
            cnt_q <= '0;
        end else begin
            state <= state_nxt;
            i_q   <= i_nxt;
            j_q   <= j_nxt;
            cnt_q <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        i_nxt     = i_q;
        j_nxt     = j_q;
        cnt_nxt   = '0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    i_nxt     = '0;
                    j_nxt     = '0;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: state_nxt = RD_WAIT;
            RD_WAIT: begin
                if (cnt_q == RD_END) state_nxt = FIRE;
                else                 cnt_nxt   = cnt_q + 1'b1;
            end
            FIRE: state_nxt = EXEC;
            EXEC: begin
                if (cnt_q == EX_END) state_nxt = OUT;
                else                 cnt_nxt   = cnt_q + 1'b1;
            end
            OUT: begin
                if (bus.res_ready) begin
                    if (j_q != LAST) begin
                        j_nxt     = j_q + 1'b1;
                        state_nxt = ISSUE;
                    end else if (i_q != LAST) begin
                        j_nxt     = '0;
                        i_nxt     = i_q + 1'b1;
                        state_nxt = ISSUE;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // abort overrides everything, including a same-cycle acceptance
        if (state != IDLE && bus.abort) begin
            state_nxt = IDLE;
            i_nxt     = '0;
            j_nxt     = '0;
        end
    end

    // Status outputs decode the state register directly, so an async
    // reset clears them without waiting for a clock edge.
    assign bus.busy      = (state != IDLE);
    assign bus.dot_go    = (state == FIRE);
    assign bus.res_valid = (state == OUT);
    assign bus.done      = (state == DONE);
    assign bus.res_idx   = IDX_W'(i_q) * IDX_W'(DIM) + IDX_W'(j_q);

    always_comb begin
        if (state == IDLE) begin
            bus.we     = bus.host_we;
            bus.dir_m1 = bus.host_dir_m1;
            bus.dir_m2 = bus.host_dir_m2;
        end else begin
            bus.we     = '0;
            bus.dir_m1 = ADDR_W'(i_q);
            bus.dir_m2 = ADDR_W'(j_q);
        end
    end

`ifdef SEQ_PERF_CNT_EN
    logic [15:0] perf_cycles_q;
    logic [15:0] perf_stalls_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_cycles_q <= '0;
            perf_stalls_q <= '0;
        end else if (state == IDLE) begin
            if (bus.start) begin
                perf_cycles_q <= '0;
                perf_stalls_q <= '0;
            end
        end else begin
            if (perf_cycles_q != '1)
                perf_cycles_q <= perf_cycles_q + 1'b1;
            if (state == OUT && !bus.res_ready && perf_stalls_q != '1)
                perf_stalls_q <= perf_stalls_q + 1'b1;
        end
    end

    assign bus.perf_cycles = perf_cycles_q;
    assign bus.perf_stalls = perf_stalls_q;
`endif
endmodule
